// File: rtl/flash_read_sched_if.sv
// Bundle of requester-side and flash-IP-side signals for flash_read_sched.
// The slave modport is the scheduler's view; master is the environment's.
interface flash_read_sched_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_i;
    logic [NUM_REQ*24-1:0] req_addr_i;
    logic [NUM_REQ*8-1:0]  req_len_i;
    logic [NUM_REQ-1:0]    gnt_o;
    logic [7:0]            byte_o;
    logic [NUM_REQ-1:0]    byte_valid_o;
    logic [NUM_REQ-1:0]    done_o;
    logic [NUM_REQ-1:0]    err_o;
    logic                  flash_read_req;
    logic [23:0]           flash_addr_read;
    logic                  flash_read_en_in;
    logic [7:0]            flash_byte_in;

    modport slave (
        input  req_i, req_addr_i, req_len_i, flash_read_en_in, flash_byte_in,
        output gnt_o, byte_o, byte_valid_o, done_o, err_o,
               flash_read_req, flash_addr_read
    );

    modport master (
        output req_i, req_addr_i, req_len_i, flash_read_en_in, flash_byte_in,
        input  gnt_o, byte_o, byte_valid_o, done_o, err_o,
               flash_read_req, flash_addr_read
    );
endinterface

// File: rtl/flash_read_sched.sv
// Round-robin burst-read scheduler sharing one serial-flash read engine
// between NUM_REQ requesters, with a per-byte response timeout.
module flash_read_sched #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    flash_read_sched_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, state_nxt;

    logic [IW-1:0]      ptr;
    logic [IW-1:0]      winner;
    logic [IW-1:0]      pick;
    logic               pick_valid;
    logic [23:0]        pick_addr;
    logic [7:0]         pick_len;
    logic [23:0]        addr;
    logic [23:0]        addr_out;
    logic [8:0]         remaining;
    logic [15:0]        tmo_cnt;
    logic               tmo_hit;
    logic [7:0]         byte_q;
    logic [NUM_REQ-1:0] byte_valid_q;
    logic [NUM_REQ-1:0] win_oh;
    logic [IW-1:0]      ptr_after;

    // First requesting index at or above ptr, wrapping around.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        int idx;
        idx        = 0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_valid && bus.req_i[idx]) begin
                pick       = IW'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    assign pick_addr = bus.req_addr_i[24*int'(pick) +: 24];
    assign pick_len  = bus.req_len_i[8*int'(pick) +: 8];
    assign win_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
    assign ptr_after = (winner == IW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
    assign tmo_hit   = ({1'b0, tmo_cnt} + 17'd1) == 17'(TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                // A returning byte wins over a timeout in the same cycle.
                if (bus.flash_read_en_in)
                    state_nxt = (remaining == 9'd1) ? S_DONE : S_ISSUE;
                else if (tmo_hit)
                    state_nxt = S_ERR;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr          <= '0;
            winner       <= '0;
            addr         <= '0;
            addr_out     <= '0;
            remaining    <= '0;
            tmo_cnt      <= '0;
            byte_q       <= '0;
            byte_valid_q <= '0;
        end else begin
            byte_valid_q <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        winner    <= pick;
                        addr      <= pick_addr;
                        addr_out  <= pick_addr;
                        remaining <= (pick_len == 8'd0) ? 9'd256 : {1'b0, pick_len};
                    end
                end
                S_ISSUE: tmo_cnt <= '0;
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (bus.flash_read_en_in) begin
                        byte_q       <= bus.flash_byte_in;
                        byte_valid_q <= win_oh;
                        addr         <= addr + 24'd1;
                        remaining    <= remaining - 9'd1;
                        // The presented address moves only when another ISSUE follows.
                        if (remaining != 9'd1) addr_out <= addr + 24'd1;
                    end
                end
                S_DONE, S_ERR: ptr <= ptr_after;
                default: ;
            endcase
        end
    end

    assign bus.gnt_o           = (state != S_IDLE) ? win_oh : '0;
    assign bus.done_o          = (state == S_DONE) ? win_oh : '0;
    assign bus.err_o           = (state == S_ERR)  ? win_oh : '0;
    assign bus.flash_read_req  = (state == S_ISSUE);
    assign bus.flash_addr_read = addr_out;
    assign bus.byte_o          = byte_q;
    assign bus.byte_valid_o    = byte_valid_q;
endmodule

// File: tb/tb_flash_read_sched.sv
// Scoreboard bench for flash_read_sched: directed bursts push expectations,
// a negedge monitor pops and compares whatever the scheduler presents.
module tb_flash_read_sched;
    localparam int NR  = 2;
    localparam int TMO = 8;

    logic clk;
    logic reset_n;
    logic en_model, en_stray;

    flash_read_sched_if #(.NUM_REQ(NR)) bus ();

    flash_read_sched #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.flash_read_en_in = en_model | en_stray;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         req;
        logic [7:0] data;
        bit         last;
    } byte_exp_t;

    byte_exp_t   exp_byte[$];
    logic [23:0] exp_addr[$];
    int          exp_gnt[$];
    int          exp_err[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_req_cyc  = 0;
    int last_done_cyc = -100;
    int rr_start_cyc  = 0;
    bit rr_mode       = 1'b0;
    bit chk_clear     = 1'b0;
    int answer_left   = -1;
    logic [NR-1:0] gnt_prev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] model_byte(input logic [23:0] a);
        return a[7:0] ^ a[23:16] ^ 8'h3C;
    endfunction

    function automatic logic [NR-1:0] oh(input int k);
        return NR'(1) << k;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Flash IP model: answers each strobe 3 cycles later while budget remains.
    initial begin
        logic [23:0] a;
        en_model = 1'b0;
        bus.flash_byte_in = '0;
        forever begin
            @(negedge clk);
            if (reset_n && bus.flash_read_req) begin
                a = bus.flash_addr_read;
                if (answer_left != 0) begin
                    if (answer_left > 0) answer_left--;
                    repeat (3) @(posedge clk);
                    #1 en_model = 1'b1;
                    bus.flash_byte_in = model_byte(a);
                    @(posedge clk);
                    #1 en_model = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        byte_exp_t e;
        int k;
        if (reset_n) begin
            if (chk_clear) begin
                check("gnt_clear_after_end", bus.gnt_o, 0);
                chk_clear = 1'b0;
            end
            check("exclusive", {$onehot0(bus.gnt_o), $onehot0(bus.byte_valid_o),
                                $onehot0(bus.done_o), $onehot0(bus.err_o)}, 4'hF);
            if (bus.flash_read_req) begin
                last_req_cyc = cyc;
                if (exp_addr.size() == 0) fail("strobe_unexpected");
                else check("strobe_addr", bus.flash_addr_read, exp_addr.pop_front());
            end
            if (|bus.byte_valid_o) begin
                if (exp_byte.size() == 0) fail("byte_unexpected");
                else begin
                    e = exp_byte.pop_front();
                    check("byte_valid", bus.byte_valid_o, oh(e.req));
                    check("byte_data", bus.byte_o, e.data);
                    check("done_with_byte", bus.done_o, e.last ? oh(e.req) : '0);
                    if (e.last) begin
                        chk_clear = 1'b1;
                        last_done_cyc = cyc;
                    end
                end
            end else if (|bus.done_o) begin
                fail("done_unexpected");
            end
            if (|bus.err_o) begin
                if (exp_err.size() == 0) fail("err_unexpected");
                else begin
                    k = exp_err.pop_front();
                    check("err_req", bus.err_o, oh(k));
                    check("err_timing", cyc - last_req_cyc, TMO + 1);
                    chk_clear = 1'b1;
                end
            end
            if ((|bus.gnt_o) && !(|gnt_prev)) begin
                if (exp_gnt.size() == 0) fail("gnt_unexpected");
                else check("gnt_order", bus.gnt_o, oh(exp_gnt.pop_front()));
                if (rr_mode && last_done_cyc >= rr_start_cyc)
                    check("rr_gap", cyc - last_done_cyc, 2);
            end
        end else begin
            chk_clear = 1'b0;
        end
        gnt_prev = bus.gnt_o;
    end

    // Push expectations for one burst; answers < 0 means the IP answers every strobe.
    task automatic push_expect(input int k, input logic [23:0] addr, input int len, input int answers);
        int n, nbytes, nstrobes;
        logic [23:0] a;
        n = (len == 0) ? 256 : len;
        nbytes   = (answers < 0 || answers >= n) ? n : answers;
        nstrobes = (nbytes == n) ? n : nbytes + 1;
        exp_gnt.push_back(k);
        for (int i = 0; i < nstrobes; i++) begin
            a = addr + 24'(i);
            exp_addr.push_back(a);
            if (i < nbytes) exp_byte.push_back('{req: k, data: model_byte(a), last: (i == n - 1)});
        end
        if (nbytes < n) exp_err.push_back(k);
    endtask

    task automatic set_req(input int k, input logic [23:0] addr, input logic [7:0] len);
        bus.req_addr_i[24*k +: 24] = addr;
        bus.req_len_i[8*k +: 8]    = len;
        bus.req_i[k]               = 1'b1;
    endtask

    task automatic wait_gnt(input int k);
        int n;
        n = 0;
        while (bus.gnt_o[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail("gnt_wait_timeout");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.gnt_o !== '0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail("idle_wait_timeout");
        repeat (2) @(negedge clk);
    endtask

    task automatic run_burst(input int k, input logic [23:0] addr, input logic [7:0] len, input int answers);
        push_expect(k, addr, int'(len), answers);
        answer_left = answers;
        @(posedge clk);
        #1 set_req(k, addr, len);
        wait_gnt(k);
        @(posedge clk);
        #1 bus.req_i[k] = 1'b0;
        wait_idle();
    endtask

    task automatic count_grants(input int want);
        int got, n;
        logic [NR-1:0] prev;
        got = 0;
        n = 0;
        prev = bus.gnt_o;
        while (got < want && n < 200) begin
            @(negedge clk);
            if ((|bus.gnt_o) && !(|prev)) got++;
            prev = bus.gnt_o;
            n++;
        end
        if (got < want) fail("rr_grant_timeout");
    endtask

    initial begin
        reset_n = 1'b0;
        en_stray = 1'b0;
        bus.req_i = '0;
        bus.req_addr_i = '0;
        bus.req_len_i = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_gnt", bus.gnt_o, 0);
        check("rst_byte", bus.byte_o, 0);
        check("rst_byte_valid", bus.byte_valid_o, 0);
        check("rst_done", bus.done_o, 0);
        check("rst_err", bus.err_o, 0);
        check("rst_read_req", bus.flash_read_req, 0);
        check("rst_addr", bus.flash_addr_read, 0);

        // Single burst, then address wrap with len 0 (256 bytes).
        run_burst(0, 24'h001000, 8'd4, -1);
        run_burst(1, 24'hFFFFFE, 8'd0, -1);

        // Round-robin with both requests held.
        push_expect(0, 24'h000100, 1, -1);
        push_expect(1, 24'h000200, 1, -1);
        push_expect(0, 24'h000100, 1, -1);
        push_expect(1, 24'h000200, 1, -1);
        answer_left = -1;
        rr_start_cyc = cyc;
        rr_mode = 1'b1;
        @(posedge clk);
        #1 set_req(0, 24'h000100, 8'd1);
        set_req(1, 24'h000200, 8'd1);
        count_grants(4);
        @(posedge clk);
        #1 bus.req_i = '0;
        wait_idle();
        rr_mode = 1'b0;

        // Timeout: only the first strobe answered, then a normal burst.
        run_burst(0, 24'h002000, 8'd2, 1);
        run_burst(1, 24'h003000, 8'd1, -1);

        // Stray strobes in IDLE and ISSUE, request dropped mid-burst.
        push_expect(0, 24'h004000, 3, -1);
        answer_left = -1;
        @(posedge clk);
        #1 set_req(0, 24'h004000, 8'd3);
        en_stray = 1'b1;
        @(posedge clk);
        #1 bus.req_i[0] = 1'b0;
        @(posedge clk);
        #1 en_stray = 1'b0;
        wait_idle();

        // Reset during WAIT of a len 8 burst; pointer returns to requester 0.
        exp_gnt.push_back(0);
        exp_addr.push_back(24'h005000);
        answer_left = -1;
        @(posedge clk);
        #1 set_req(0, 24'h005000, 8'd8);
        wait_gnt(0);
        @(posedge clk);
        #1 reset_n = 1'b0;
        bus.req_i = '0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_gnt", bus.gnt_o, 0);
        check("mid_rst_done", bus.done_o, 0);
        check("mid_rst_err", bus.err_o, 0);
        check("mid_rst_read_req", bus.flash_read_req, 0);
        check("mid_rst_addr", bus.flash_addr_read, 0);
        check("mid_rst_byte_valid", bus.byte_valid_o, 0);
        repeat (4) @(posedge clk);

        push_expect(0, 24'h000600, 1, -1);
        push_expect(1, 24'h000700, 1, -1);
        rr_start_cyc = cyc;
        rr_mode = 1'b1;
        #1 set_req(0, 24'h000600, 8'd1);
        set_req(1, 24'h000700, 8'd1);
        count_grants(2);
        @(posedge clk);
        #1 bus.req_i = '0;
        wait_idle();
        rr_mode = 1'b0;

        repeat (5) @(negedge clk);
        check("left_gnt", exp_gnt.size(), 0);
        check("left_addr", exp_addr.size(), 0);
        check("left_byte", exp_byte.size(), 0);
        check("left_err", exp_err.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/flash_read_sched.md
# flash_read_sched

Burst-read scheduler that shares the single serial-flash read engine between `NUM_REQ` requesters, such as the MCU flash-read register wrapper, the boot loader and a DMA port. It sits between the requesters and the flash read IP. For each granted request it issues one read strobe per byte, forwards each returned byte, and advances a 24-bit address until the requested length has been transferred. A per-byte timeout aborts a burst when the engine stops responding.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 1024: number of WAIT cycles without `flash_read_en_in` before the burst is aborted. Range 2..65535.

All ports are listed below. The block uses one clock, `clk`. Reset is `reset_n`, synchronous and active-low.

- `clk`, input, 1: system clock.
- `reset_n`, input, 1: synchronous active-low reset.
- `req_i`, input, `NUM_REQ`: per-requester burst request level.
- `req_addr_i`, input, `NUM_REQ*24`: start byte address. Requester k uses bits [24k+23:24k].
- `req_len_i`, input, `NUM_REQ*8`: burst length in bytes. A value of 0 means 256 bytes.
- `gnt_o`, output, `NUM_REQ`: one-hot grant, held for the whole burst.
- `byte_o`, output, 8: returned flash byte, shared by all requesters.
- `byte_valid_o`, output, `NUM_REQ`: one-cycle strobe qualifying `byte_o` for requester k.
- `done_o`, output, `NUM_REQ`: one-cycle pulse when the burst completed normally.
- `err_o`, output, `NUM_REQ`: one-cycle pulse when the burst was aborted by timeout.
- `flash_read_req`, output, 1: one-cycle read strobe to the flash read IP.
- `flash_addr_read`, output, 24: byte address for the flash read IP.
- `flash_read_en_in`, input, 1: one-cycle strobe from the IP indicating `flash_byte_in` is valid.
- `flash_byte_in`, input, 8: byte returned by the IP.

## Operation
The block has five states: IDLE, ISSUE, WAIT, DONE and ERR.

- **Reset.** State goes to IDLE. The round-robin pointer is set to 0, so requester 0 has highest priority. All outputs go to 0, including `flash_addr_read` and `byte_o`. The address, remaining-count and timeout registers are cleared.
- **IDLE.**
  - If any `req_i` bit is set, the winner is the first set bit searching upward from the pointer and wrapping around.
  - On the winning cycle the block latches the winner's address and length. A length of 0 loads 256, so the remaining counter is 9 bits.
  - It then sets the one-hot `gnt_o` and moves to ISSUE.
  - If no `req_i` bit is set, it stays in IDLE.
- **ISSUE.**
  - `flash_read_req` is 1 for exactly this one cycle.
  - `flash_addr_read` equals the current address.
  - The timeout counter is cleared, and the state moves to WAIT.
- **WAIT.**
  - The timeout counter increments every cycle.
  - If `flash_read_en_in` = 1:
    - `flash_byte_in` is registered to `byte_o` and `byte_valid_o[winner]` is pulsed on the next cycle.
    - The address increments by 1 modulo 2^24, so 0xFFFFFF wraps to 0x000000.
    - The remaining count decrements.
    - If the remaining count was 1, the next state is DONE; otherwise it is ISSUE.
  - Else, if the counter reaches `TIMEOUT_CYCLES`, the next state is ERR.
  - `flash_read_en_in` has priority over timeout in the same cycle.
- **DONE.**
  - `done_o[winner]` is 1 for one cycle, in the same cycle as the last `byte_valid_o`.
  - The pointer is set to winner+1 mod `NUM_REQ`.
  - `gnt_o` clears and the state moves to IDLE.
- **ERR.**
  - `err_o[winner]` is 1 for one cycle.
  - The pointer advances the same way as in DONE.
  - `gnt_o` clears and the state moves to IDLE.
  - Bytes already delivered stand. No further bytes are delivered for that burst.
- **Held signals.** `flash_addr_read` holds its value from ISSUE through WAIT. It changes only on entering ISSUE.
- **Request sampling.**
  - `req_i`, `req_addr_i` and `req_len_i` are sampled only in IDLE.
  - Deasserting `req_i` mid-burst has no effect; the burst runs to DONE or ERR.
  - A requester that still holds `req_i` after DONE competes again, with its priority now lowest.
- **Stray strobes.** `flash_read_en_in` in IDLE, ISSUE, DONE or ERR is ignored: no byte is forwarded and no state changes.
- **Output exclusivity.** At most one bit of `gnt_o`, `byte_valid_o`, `done_o` and `err_o` is high in any cycle.

## Timing
- **Grant latency.** Let `req_i[k]` be seen in IDLE at cycle t.
  - `gnt_o[k]` = 1 and the state is ISSUE at t+1.
  - `flash_read_req` = 1 at t+1.
  - WAIT starts at t+2.
- **Byte latency.** If `flash_read_en_in` arrives at cycle w:
  - `byte_o` and `byte_valid_o` are asserted at w+1.
  - The next ISSUE, if any, is at w+1.
  - Per-byte overhead is 2 cycles plus the IP latency.
- **Last byte.**
  - DONE and `done_o` occur at w+1.
  - `gnt_o` = 0 and the state is IDLE at w+2.
  - The earliest next grant is at w+3.
- **Timeout.** With WAIT entered at cycle s and no strobe, ERR occurs at s+`TIMEOUT_CYCLES`, and IDLE follows one cycle later.
- **Reset mid-burst.** Reset at any state or cycle returns to the reset values on the next edge. No `done_o` or `err_o` is emitted.

## Test plan
- **Single burst.** Requester 0 requests addr 0x001000, len 4; the IP model answers 3 cycles after each strobe.
  - Expect 4 strobes at addresses 0x001000..0x001003.
  - Expect 4 `byte_valid_o[0]` pulses carrying the model bytes.
  - Expect `done_o[0]` with the 4th byte and `gnt_o` clear one cycle later.
- **Wrap and len=0.** Request addr 0xFFFFFE, len 0.
  - Expect 256 bytes at addresses 0xFFFFFE, 0xFFFFFF, 0x000000, … 0x0000FD.
  - Expect the done pulse after the 256th byte.
- **Round-robin.** `req_i` = 2'b11 held continuously, len 1 each.
  - Expect grants 0, 1, 0, 1.
  - Expect no cycle with two grant bits set, and no gap longer than 2 IDLE-related cycles between bursts.
- **Timeout.** `TIMEOUT_CYCLES` = 8, len 2; the model answers the first strobe only.
  - Expect 1 `byte_valid_o`, then `err_o` exactly 8 cycles after the second WAIT entry.
  - Expect no `done_o`.
  - Expect the next request to be granted normally.
- **Stray strobe and dropped request.**
  - `flash_read_en_in` pulsed in IDLE and ISSUE produces no `byte_valid_o`.
  - `req_i` dropped mid-burst still gives the full length and `done_o`.
- **Reset mid-burst.** Assert `reset_n` = 0 for 1 cycle during WAIT of a len 8 burst.
  - Expect all outputs 0 on the next edge, with no done or error pulse.
  - Expect the pointer back to 0: with `req_i` = 2'b11, requester 0 is granted first.
